cell_link_arbiter: RTL and testbench

Packet-mode round-robin arbiter that merges up to three AXI-Stream sources (incoming cell link, local BPM, local FMPS) into one stream for the cell-link forwarder. It grants whole packets, never interleaves beats, and restarts its schedule on every FA strobe. A cycle watchdog bounds any packet, and an optional per-FA-interval packet budget limits each source. It sits between the per-source packet FIFOs and the forwarding/deduplication logic on the Aurora user clock.

---
 rtl/cell_link_arbiter.sv | 173 +++++++++++++++++
 tb/tb_cell_link_arbiter.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cell_link_arbiter.sv
// Packet-mode round-robin arbiter merging NUM_SOURCES AXI-Stream sources into one registered stream.
// Optional per-FA-interval packet budget is compiled in with CELL_LINK_ARB_BUDGET_EN.
module cell_link_arbiter #(
  parameter int unsigned NUM_SOURCES        = 3,
  parameter int unsigned DATA_WIDTH         = 32,
  parameter int unsigned WATCHDOG_WIDTH     = 7,
  parameter int unsigned MAX_PACKETS_PER_FA = 32
) (
  input  logic                              auroraUserClk,
  input  logic                              auroraUserResetN,
  input  logic                              auroraFAstrobe,
  input  logic [NUM_SOURCES-1:0]            sTVALID,
  input  logic [NUM_SOURCES-1:0]            sTLAST,
  input  logic [NUM_SOURCES*DATA_WIDTH-1:0] sTDATA,
  output logic [NUM_SOURCES-1:0]            sTREADY,
  output logic                              mTVALID,
  output logic                              mTLAST,
  output logic [DATA_WIDTH-1:0]             mTDATA,
  input  logic                              mTREADY,
  output logic [NUM_SOURCES-1:0]            grant,
  output logic                              timeoutPulse
);

  localparam int unsigned IdxW = $clog2(NUM_SOURCES);

  if (NUM_SOURCES < 2 || NUM_SOURCES > 4 || MAX_PACKETS_PER_FA == 0) begin : g_param_check
    $error("cell_link_arbiter: unsupported parameter combination");
  end

  typedef enum logic [1:0] {StIdle, StGrant, StDrain} state_e;

  state_e                    state_q;
  logic [IdxW-1:0]           idx_q;
  logic [IdxW-1:0]           rr_ptr_q;
  logic [NUM_SOURCES-1:0]    grant_q;
  logic [WATCHDOG_WIDTH-1:0] wdog_q;
  logic                      m_valid_q;
  logic                      m_last_q;
  logic [DATA_WIDTH-1:0]     m_data_q;
  logic                      timeout_q;

  logic [NUM_SOURCES-1:0] exhausted;
  logic [NUM_SOURCES-1:0] eligible;
  logic                   sel_found;
  logic [IdxW-1:0]        sel_idx;
  logic [IdxW-1:0]        rr_ptr_d;
  logic                   slot_free;
  logic                   src_hs;
  logic                   src_last;
  logic [DATA_WIDTH-1:0]  src_data;

  assign eligible  = sTVALID & ~exhausted;
  assign slot_free = !m_valid_q || mTREADY;
  assign src_hs    = sTVALID[idx_q] && sTREADY[idx_q];
  assign src_last  = sTLAST[idx_q];
  assign src_data  = sTDATA[idx_q*DATA_WIDTH +: DATA_WIDTH];

  // First eligible source at or after the round-robin pointer, wrapping.
  always_comb begin
    int unsigned cand;
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = 0;
    for (int unsigned k = 0; k < NUM_SOURCES; k++) begin
      cand = (int'(rr_ptr_q) + k) % NUM_SOURCES;
      if (!sel_found && eligible[IdxW'(cand)]) begin
        sel_found = 1'b1;
        sel_idx   = IdxW'(cand);
      end
    end
    rr_ptr_d = (sel_idx == IdxW'(NUM_SOURCES - 1)) ? '0 : sel_idx + 1'b1;
  end

  always_comb begin
    sTREADY = '0;
    unique case (state_q)
      StGrant: sTREADY[idx_q] = (wdog_q != '0) && slot_free;
      StDrain: sTREADY[idx_q] = 1'b1;
      default: sTREADY = '0;
    endcase
  end

`ifdef CELL_LINK_ARB_BUDGET_EN
  localparam int unsigned CntW = $clog2(MAX_PACKETS_PER_FA + 1);

  logic [CntW-1:0] pkt_cnt_q [NUM_SOURCES];

  always_ff @(posedge auroraUserClk) begin
    if (!auroraUserResetN || auroraFAstrobe) begin
      for (int i = 0; i < NUM_SOURCES; i++) pkt_cnt_q[i] <= '0;
    end else if (state_q == StIdle && sel_found &&
                 pkt_cnt_q[sel_idx] != CntW'(MAX_PACKETS_PER_FA)) begin
      pkt_cnt_q[sel_idx] <= pkt_cnt_q[sel_idx] + 1'b1;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_SOURCES; i++) begin
      exhausted[i] = (pkt_cnt_q[i] == CntW'(MAX_PACKETS_PER_FA));
    end
  end
`else
  assign exhausted = '0;
`endif

  always_ff @(posedge auroraUserClk) begin
    if (!auroraUserResetN) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      rr_ptr_q  <= '0;
      grant_q   <= '0;
      wdog_q    <= '1;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      m_data_q  <= '0;
      timeout_q <= 1'b0;
    end else if (auroraFAstrobe) begin
      // In-flight packet is truncated; downstream resets on the same strobe.
      state_q   <= StIdle;
      rr_ptr_q  <= '0;
      grant_q   <= '0;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      if (mTREADY) m_valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (sel_found) begin
            state_q  <= StGrant;
            idx_q    <= sel_idx;
            grant_q  <= NUM_SOURCES'(1) << sel_idx;
            wdog_q   <= '1;
            rr_ptr_q <= rr_ptr_d;
          end
        end
        StGrant: begin
          if (wdog_q != '0) wdog_q <= wdog_q - 1'b1;
          if (src_hs) begin
            m_valid_q <= 1'b1;
            m_data_q  <= src_data;
            m_last_q  <= src_last;
            if (src_last) begin
              state_q <= StIdle;
              grant_q <= '0;
            end
          end else if (wdog_q == '0 && slot_free) begin
            m_valid_q <= 1'b1;
            m_last_q  <= 1'b1;
            m_data_q  <= {1'b1, {(DATA_WIDTH-1){1'b0}}};
            timeout_q <= 1'b1;
            state_q   <= StDrain;
          end
        end
        StDrain: begin
          if (src_hs && src_last) begin
            state_q <= StIdle;
            grant_q <= '0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign mTVALID      = m_valid_q;
  assign mTLAST       = m_last_q;
  assign mTDATA       = m_data_q;
  assign grant        = grant_q;
  assign timeoutPulse = timeout_q;

endmodule

// File: tb/tb_cell_link_arbiter.sv
// Directed self-checking bench for cell_link_arbiter: sources are modelled as beat queues,
// the merged output is logged at the falling edge and compared against hand-computed vectors.
module tb_cell_link_arbiter;

  logic        clk;
  logic        rst_n;
  logic        fa;
  logic [2:0]  s_valid;
  logic [2:0]  s_last;
  logic [95:0] s_data;
  logic [2:0]  s_ready;
  logic        m_valid;
  logic        m_last;
  logic [31:0] m_data;
  logic        m_ready;
  logic [2:0]  gnt;
  logic        to_pulse;

  cell_link_arbiter #(
    .NUM_SOURCES       (3),
    .DATA_WIDTH        (32),
    .WATCHDOG_WIDTH    (7),
    .MAX_PACKETS_PER_FA(2)
  ) dut (
    .auroraUserClk   (clk),
    .auroraUserResetN(rst_n),
    .auroraFAstrobe  (fa),
    .sTVALID         (s_valid),
    .sTLAST          (s_last),
    .sTDATA          (s_data),
    .sTREADY         (s_ready),
    .mTVALID         (m_valid),
    .mTLAST          (m_last),
    .mTDATA          (m_data),
    .mTREADY         (m_ready),
    .grant           (gnt),
    .timeoutPulse    (to_pulse)
  );

  typedef struct packed {
    logic [31:0] data;
    logic        last;
    logic [2:0]  gnt;
    logic [31:0] cyc;
  } beat_t;

  logic [32:0] q0[$];
  logic [32:0] q1[$];
  logic [32:0] q2[$];
  beat_t       out_q[$];
  logic [2:0]  hs_s;
  int          cyc;
  int          to_cnt;
  logic [31:0] to_data;
  logic        toggle_rdy;
  int          n_vec;
  int          n_err;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1);
  end

  always @(negedge clk) begin
    hs_s = s_valid & s_ready;
    if (m_valid && m_ready) out_q.push_back('{data: m_data, last: m_last, gnt: gnt, cyc: cyc});
    if (to_pulse) begin
      to_cnt++;
      to_data = m_data;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive();
    s_valid = {q2.size() != 0, q1.size() != 0, q0.size() != 0};
    {s_last[0], s_data[31:0]}  = (q0.size() != 0) ? q0[0] : 33'h0;
    {s_last[1], s_data[63:32]} = (q1.size() != 0) ? q1[0] : 33'h0;
    {s_last[2], s_data[95:64]} = (q2.size() != 0) ? q2[0] : 33'h0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (hs_s[0] && q0.size() != 0) void'(q0.pop_front());
    if (hs_s[1] && q1.size() != 0) void'(q1.pop_front());
    if (hs_s[2] && q2.size() != 0) void'(q2.pop_front());
    if (toggle_rdy) m_ready = ~m_ready;
    cyc++;
    drive();
    #2;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    tick();
    tick();
    while (!(q0.size() == 0 && q1.size() == 0 && q2.size() == 0 && gnt == 3'b000 && !m_valid)
           && n < budget) begin
      tick();
      n++;
    end
    check_eq({tag, "_idle"}, 32'(n < budget), 32'd1);
  endtask

  task automatic wait_grant(input string tag, input logic [2:0] exp, input int budget);
    int n = 0;
    while (gnt !== exp && n < budget) begin
      tick();
      n++;
    end
    check_eq(tag, 32'(gnt), 32'(exp));
  endtask

  task automatic pulse_fa();
    fa = 1'b1;
    tick();
    fa = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_sready"}, 32'(s_ready), 32'd0);
    check_eq({tag, "_mvalid"}, 32'(m_valid), 32'd0);
    check_eq({tag, "_mlast"}, 32'(m_last), 32'd0);
    check_eq({tag, "_mdata"}, m_data, 32'd0);
    check_eq({tag, "_grant"}, 32'(gnt), 32'd0);
    check_eq({tag, "_tpulse"}, 32'(to_pulse), 32'd0);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    cyc = 0;
    to_cnt = 0;
    to_data = '0;
    toggle_rdy = 1'b0;
    hs_s = '0;
    rst_n = 1'b0;
    fa = 1'b0;
    m_ready = 1'b1;
    drive();

    // Reset state
    tick();
    tick();
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick();

    // Three simultaneous 4-beat packets
    for (int j = 0; j < 4; j++) begin
      q0.push_back({j == 3, 32'h100 + 32'(j)});
      q1.push_back({j == 3, 32'h200 + 32'(j)});
      q2.push_back({j == 3, 32'h300 + 32'(j)});
    end
    drive();
    out_q.delete();
    wait_idle("t1", 100);
    check_eq("t1_count", 32'(out_q.size()), 32'd12);
    for (int k = 0; k < 12 && k < out_q.size(); k++) begin
      check_eq("t1_data", out_q[k].data, 32'h100 * 32'(k / 4 + 1) + 32'(k % 4));
      check_eq("t1_last", 32'(out_q[k].last), 32'(k % 4 == 3));
      if (k % 4 == 0) check_eq("t1_grant", 32'(out_q[k].gnt), 32'(3'b001 << (k / 4)));
      if (k > 0) check_eq("t1_gap", out_q[k].cyc - out_q[k-1].cyc, (k % 4 == 0) ? 32'd2 : 32'd1);
    end

    // Downstream backpressure toggling every cycle
    q1.push_back({1'b0, 32'h11});
    q1.push_back({1'b0, 32'h22});
    q1.push_back({1'b1, 32'h33});
    drive();
    out_q.delete();
    toggle_rdy = 1'b1;
    wait_idle("t2", 100);
    toggle_rdy = 1'b0;
    m_ready = 1'b1;
    check_eq("t2_count", 32'(out_q.size()), 32'd3);
    if (out_q.size() == 3) begin
      check_eq("t2_d0", out_q[0].data, 32'h11);
      check_eq("t2_d1", out_q[1].data, 32'h22);
      check_eq("t2_d2", out_q[2].data, 32'h33);
      check_eq("t2_lasts", 32'({out_q[0].last, out_q[1].last, out_q[2].last}), 32'b001);
    end

    // Watchdog: 200 beats without TLAST, then a TLAST beat
    for (int j = 0; j < 200; j++) q0.push_back({1'b0, 32'h1000 + 32'(j)});
    q0.push_back({1'b1, 32'h1000 + 32'd200});
    drive();
    out_q.delete();
    to_cnt = 0;
    wait_idle("t3", 400);
    check_eq("t3_count", 32'(out_q.size()), 32'd128);
    if (out_q.size() == 128) begin
      check_eq("t3_first", out_q[0].data, 32'h1000);
      check_eq("t3_beat126", out_q[126].data, 32'h1000 + 32'd126);
      check_eq("t3_beat126_last", 32'(out_q[126].last), 32'd0);
      check_eq("t3_term_data", out_q[127].data, 32'h8000_0000);
      check_eq("t3_term_last", 32'(out_q[127].last), 32'd1);
      check_eq("t3_term_latency", out_q[127].cyc - out_q[0].cyc, 32'd127);
    end
    check_eq("t3_pulse_count", 32'(to_cnt), 32'd1);
    check_eq("t3_pulse_data", to_data, 32'h8000_0000);

    // FA strobe mid-packet on source 2 with source 0 pending
    for (int j = 0; j < 8; j++) q2.push_back({j == 7, 32'h400 + 32'(j)});
    drive();
    wait_grant("t4_grant2", 3'b100, 20);
    tick();
    tick();
    tick();
    q0.push_back({1'b0, 32'h500});
    q0.push_back({1'b1, 32'h501});
    drive();
    pulse_fa();
    check_eq("t4_mvalid", 32'(m_valid), 32'd0);
    check_eq("t4_grant_clr", 32'(gnt), 32'd0);
    out_q.delete();
    for (int n = 0; n < 20 && out_q.size() == 0; n++) tick();
    check_eq("t4_first_data", (out_q.size() != 0) ? out_q[0].data : 32'hdead_beef, 32'h500);
    check_eq("t4_first_grant", (out_q.size() != 0) ? 32'(out_q[0].gnt) : 32'hf, 32'b001);
    wait_idle("t4", 100);

    // Strobe restarts the pointer: source 0 mid-packet, source 1 pending
    for (int j = 0; j < 4; j++) q0.push_back({j == 3, 32'h700 + 32'(j)});
    drive();
    wait_grant("t4b_grant0", 3'b001, 20);
    tick();
    q1.push_back({1'b1, 32'h600});
    drive();
    pulse_fa();
    out_q.delete();
    for (int n = 0; n < 20 && out_q.size() == 0; n++) tick();
    check_eq("t4b_first_data", (out_q.size() != 0) ? out_q[0].data : 32'hdead_beef, 32'h702);
    wait_idle("t4b", 100);

    // Per-FA packet budget with single-beat packets on source 0
    pulse_fa();
    out_q.delete();
    for (int j = 0; j < 6; j++) q0.push_back({1'b1, 32'h800 + 32'(j)});
    drive();
    for (int n = 0; n < 30; n++) tick();
`ifdef CELL_LINK_ARB_BUDGET_EN
    check_eq("t5_count_fa1", 32'(out_q.size()), 32'd2);
`else
    check_eq("t5_count_fa1", 32'(out_q.size()), 32'd6);
`endif
    check_eq("t5_sready0", 32'(s_ready[0]), 32'd0);
    check_eq("t5_grant_idle", 32'(gnt), 32'd0);
    pulse_fa();
    for (int n = 0; n < 30; n++) tick();
`ifdef CELL_LINK_ARB_BUDGET_EN
    check_eq("t5_count_fa2", 32'(out_q.size()), 32'd4);
`else
    check_eq("t5_count_fa2", 32'(out_q.size()), 32'd6);
`endif
    if (out_q.size() >= 2) check_eq("t5_data1", out_q[1].data, 32'h801);
    q0.delete();
    drive();
    pulse_fa();

    // Reset asserted during GRANT
    for (int j = 0; j < 10; j++) q1.push_back({j == 9, 32'h900 + 32'(j)});
    drive();
    wait_grant("t6_grant1", 3'b010, 20);
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    check_reset_outputs("t6_rst_a");
    tick();
    tick();
    check_reset_outputs("t6_rst_b");
    rst_n = 1'b1;
    wait_grant("t6_regrant", 3'b010, 20);
    wait_idle("t6", 100);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
